// File: rtl/drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : drive_arbiter
// Purpose  : Chooses the rover drive command from either the IR remote
//            (manual) or the vision classifier (autonomous). It sequences
//            mode changes, debounces the vision direction, stops the motors
//            when a manual command is not refreshed (dead-man), and runs a
//            rotate-left search pattern when the target is lost.
// Ports    : clk_50     in   system clock, 50 MHz
//            resend     in   synchronous active-high reset
//            ir_cmd     in   [2:0] decoded IR command, sampled on a press
//            ir_toggle  in   inverts once per new IR press
//            vis_dir    in   [2:0] classifier direction (values > 4 mean 0)
//            vis_valid  in   orange target detected
//            fast       in   mic speed request (used in AUTO only)
//            motor_cmd  out  [2:0] 0 stop, 1 fwd, 2 back, 3 left, 4 right
//            speed_sel  out  1 = fast
//            mode       out  [1:0] 00 STOP, 01 MANUAL, 10 AUTO, 11 SEARCH
//            cmd_strobe out  one-cycle pulse when motor_cmd changes value
// Options  : DRIVE_ARB_SEARCH_EN - when defined, target loss enters the
//            SEARCH mode; otherwise target loss only stops the motors and
//            the block stays in AUTO.
// Revision : 1.0 - initial release
// ============================================================================
module drive_arbiter #(
  parameter int DEBOUNCE_CYC    = 250000,
  parameter int LOST_CYC        = 25000000,
  parameter int SEARCH_CYC      = 250000000,
  parameter int MANUAL_HOLD_CYC = 50000000
) (
  input  logic       clk_50,
  input  logic       resend,
  input  logic [2:0] ir_cmd,
  input  logic       ir_toggle,
  input  logic [2:0] vis_dir,
  input  logic       vis_valid,
  input  logic       fast,
  output logic [2:0] motor_cmd,
  output logic       speed_sel,
  output logic [1:0] mode,
  output logic       cmd_strobe
);

  // One counter width sized for the largest interval.
  localparam int c_max_a   = (DEBOUNCE_CYC > LOST_CYC) ? DEBOUNCE_CYC : LOST_CYC;
  localparam int c_max_b   = (SEARCH_CYC > MANUAL_HOLD_CYC) ? SEARCH_CYC : MANUAL_HOLD_CYC;
  localparam int c_max_cyc = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int CW        = $clog2(c_max_cyc + 1);

  localparam logic [CW-1:0] c_one      = CW'(1);
  localparam logic [CW-1:0] c_sat      = '1;
  localparam logic [CW-1:0] c_deb_lim  = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] c_lost_lim = CW'(LOST_CYC);
  localparam logic [CW-1:0] c_hold_lim = CW'(MANUAL_HOLD_CYC);
`ifdef DRIVE_ARB_SEARCH_EN
  localparam logic [CW-1:0] c_search_lim = CW'(SEARCH_CYC);
`endif

  typedef enum logic [1:0] {
    MODE_STOP   = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_SEARCH = 2'b11
  } mode_t;

  mode_t         mode_q, mode_d;
  logic [2:0]    motor_q, motor_d;
  logic          speed_q, speed_d;
  logic          strobe_q, strobe_d;
  logic          toggle_q;
  logic [2:0]    cand_q, cand_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [CW-1:0] lost_q, lost_d;
  logic [CW-1:0] hold_q, hold_d;
`ifdef DRIVE_ARB_SEARCH_EN
  logic [CW-1:0] search_q, search_d;
  logic [CW-1:0] w_search_inc;
`endif

  logic          w_press;
  logic [2:0]    w_vis_n;
  logic [CW-1:0] w_deb_inc;
  logic [CW-1:0] w_lost_inc;
  logic [CW-1:0] w_hold_inc;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == c_sat) ? x : x + c_one;
  endfunction

  assign w_press    = (ir_toggle != toggle_q);
  assign w_vis_n    = (vis_dir > 3'd4) ? 3'd0 : vis_dir;
  assign w_deb_inc  = sat_inc(deb_q);
  assign w_lost_inc = sat_inc(lost_q);
  assign w_hold_inc = sat_inc(hold_q);
`ifdef DRIVE_ARB_SEARCH_EN
  assign w_search_inc = sat_inc(search_q);
`endif

  always_comb begin
    mode_d  = mode_q;
    motor_d = motor_q;
    cand_d  = cand_q;
    deb_d   = deb_q;
    lost_d  = lost_q;
    hold_d  = hold_q;
`ifdef DRIVE_ARB_SEARCH_EN
    search_d = search_q;
`endif

    // An accepted IR press overrides whatever the current mode would do.
    if (w_press && (ir_cmd != 3'd7)) begin
      case (ir_cmd)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          mode_d  = MODE_MANUAL;
          motor_d = ir_cmd;
          hold_d  = '0;
        end
        3'd5: begin
          mode_d  = MODE_AUTO;
          motor_d = 3'd0;
          cand_d  = 3'd0;
          deb_d   = '0;
          lost_d  = '0;
        end
        default: begin
          mode_d  = MODE_STOP;
          motor_d = 3'd0;
        end
      endcase
    end else begin
      case (mode_q)
        MODE_STOP: begin
          motor_d = 3'd0;
        end
        MODE_MANUAL: begin
          hold_d = w_hold_inc;
          if (w_hold_inc >= c_hold_lim) begin
            motor_d = 3'd0;
          end
        end
        MODE_AUTO: begin
          if (!vis_valid) begin
            lost_d = w_lost_inc;
            deb_d  = '0;
            if (w_lost_inc >= c_lost_lim) begin
`ifdef DRIVE_ARB_SEARCH_EN
              mode_d   = MODE_SEARCH;
              motor_d  = 3'd3;
              search_d = '0;
`else
              motor_d = 3'd0;
`endif
            end else if (deb_q >= c_deb_lim) begin
              motor_d = cand_q;
            end
          end else begin
            lost_d = '0;
            // A new direction becomes the candidate and counts as its
            // first stable cycle.
            if (w_vis_n == cand_q) begin
              deb_d = w_deb_inc;
            end else begin
              cand_d = w_vis_n;
              deb_d  = c_one;
            end
            if (deb_q >= c_deb_lim) begin
              motor_d = cand_q;
            end
          end
        end
`ifdef DRIVE_ARB_SEARCH_EN
        MODE_SEARCH: begin
          if (vis_valid) begin
            mode_d  = MODE_AUTO;
            motor_d = 3'd0;
            cand_d  = 3'd0;
            deb_d   = '0;
            lost_d  = '0;
          end else begin
            search_d = w_search_inc;
            if (w_search_inc >= c_search_lim) begin
              mode_d  = MODE_STOP;
              motor_d = 3'd0;
            end else begin
              motor_d = 3'd3;
            end
          end
        end
`endif
        default: begin
          mode_d  = MODE_STOP;
          motor_d = 3'd0;
        end
      endcase
    end

    speed_d  = (mode_d == MODE_AUTO) ? fast : 1'b0;
    strobe_d = (motor_d != motor_q);
  end

  always_ff @(posedge clk_50) begin
    // toggle_q tracks ir_toggle even in reset so no press appears on release.
    toggle_q <= ir_toggle;
    if (resend) begin
      mode_q   <= MODE_STOP;
      motor_q  <= 3'd0;
      speed_q  <= 1'b0;
      strobe_q <= 1'b0;
      cand_q   <= 3'd0;
      deb_q    <= '0;
      lost_q   <= '0;
      hold_q   <= '0;
`ifdef DRIVE_ARB_SEARCH_EN
      search_q <= '0;
`endif
    end else begin
      mode_q   <= mode_d;
      motor_q  <= motor_d;
      speed_q  <= speed_d;
      strobe_q <= strobe_d;
      cand_q   <= cand_d;
      deb_q    <= deb_d;
      lost_q   <= lost_d;
      hold_q   <= hold_d;
`ifdef DRIVE_ARB_SEARCH_EN
      search_q <= search_d;
`endif
    end
  end

  assign motor_cmd  = motor_q;
  assign speed_sel  = speed_q;
  assign mode       = mode_q;
  assign cmd_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_drive_arbiter
// Purpose  : Directed self-checking bench for drive_arbiter with shortened
//            intervals (debounce 4, lost 8, search 16, manual hold 10).
//            Expectations for target loss follow DRIVE_ARB_SEARCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drive_arbiter;

  logic       clk_50 = 1'b0;
  logic       resend = 1'b1;
  logic [2:0] ir_cmd = 3'd0;
  logic       ir_toggle = 1'b0;
  logic [2:0] vis_dir = 3'd0;
  logic       vis_valid = 1'b0;
  logic       fast = 1'b0;
  logic [2:0] motor_cmd;
  logic       speed_sel;
  logic [1:0] mode;
  logic       cmd_strobe;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] e;

  // {mode, motor_cmd, speed_sel, cmd_strobe}
  wire [6:0] w_obs = {mode, motor_cmd, speed_sel, cmd_strobe};

  drive_arbiter #(
    .DEBOUNCE_CYC   (4),
    .LOST_CYC       (8),
    .SEARCH_CYC     (16),
    .MANUAL_HOLD_CYC(10)
  ) u_dut (
    .clk_50    (clk_50),
    .resend    (resend),
    .ir_cmd    (ir_cmd),
    .ir_toggle (ir_toggle),
    .vis_dir   (vis_dir),
    .vis_valid (vis_valid),
    .fast      (fast),
    .motor_cmd (motor_cmd),
    .speed_sel (speed_sel),
    .mode      (mode),
    .cmd_strobe(cmd_strobe)
  );

  always #5 clk_50 = ~clk_50;

  function automatic logic [6:0] exp_v(input logic [1:0] m, input logic [2:0] c,
                                       input logic s, input logic st);
    return {m, c, s, st};
  endfunction

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic press(input logic [2:0] c);
    ir_cmd    = c;
    ir_toggle = ~ir_toggle;
  endtask

  task automatic test_reset();
    resend = 1'b1;
    repeat (3) tick();
    e = exp_v(2'd0, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL reset_state: got %b want %b", w_obs, e); end
    resend = 1'b0;
    vis_valid = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL stop_idle: got %b want %b", w_obs, e); end
    vis_valid = 1'b0;
  endtask

  task automatic test_manual();
    press(3'd1);
    tick();
    e = exp_v(2'd1, 3'd1, 1'b0, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL manual_press: got %b want %b", w_obs, e); end
    tick();
    e = exp_v(2'd1, 3'd1, 1'b0, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL manual_strobe_off: got %b want %b", w_obs, e); end
    repeat (8) tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL manual_hold_9: got %b want %b", w_obs, e); end
    tick();
    e = exp_v(2'd1, 3'd0, 1'b0, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL deadman: got %b want %b", w_obs, e); end
    tick();
    e = exp_v(2'd1, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL deadman_after: got %b want %b", w_obs, e); end
  endtask

  task automatic test_auto();
    vis_valid = 1'b1;
    vis_dir   = 3'd4;
    fast      = 1'b1;
    press(3'd5);
    tick();
    e = exp_v(2'd2, 3'd0, 1'b1, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL auto_enter: got %b want %b", w_obs, e); end
    repeat (4) tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL auto_deb_4: got %b want %b", w_obs, e); end
    tick();
    e = exp_v(2'd2, 3'd4, 1'b1, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL auto_apply: got %b want %b", w_obs, e); end
    e = exp_v(2'd2, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) vis_dir = (i % 6 == 0) ? 3'd1 : 3'd2;
      tick();
      n_checks++;
      if (w_obs !== e) begin n_fail++; $display("FAIL auto_toggle[%0d]: got %b want %b", i, w_obs, e); end
    end
    vis_dir = 3'd7;
    repeat (4) tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL vis_gt4_wait: got %b want %b", w_obs, e); end
    tick();
    e = exp_v(2'd2, 3'd0, 1'b1, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL vis_gt4_zero: got %b want %b", w_obs, e); end
    vis_dir = 3'd1;
    repeat (5) tick();
    e = exp_v(2'd2, 3'd1, 1'b1, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL auto_dir1: got %b want %b", w_obs, e); end
    fast = 1'b0;
    tick();
    e = exp_v(2'd2, 3'd1, 1'b0, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL auto_fast_off: got %b want %b", w_obs, e); end
    fast = 1'b1;
    tick();
    e = exp_v(2'd2, 3'd1, 1'b1, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL auto_fast_on: got %b want %b", w_obs, e); end
  endtask

  task automatic test_lost();
    e = exp_v(2'd2, 3'd1, 1'b1, 1'b0);
    vis_valid = 1'b0;
    repeat (7) tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL dropout_7: got %b want %b", w_obs, e); end
    vis_valid = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL dropout_restore: got %b want %b", w_obs, e); end
    vis_valid = 1'b0;
    repeat (7) tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL lost_7: got %b want %b", w_obs, e); end
    tick();
`ifdef DRIVE_ARB_SEARCH_EN
    e = exp_v(2'd3, 3'd3, 1'b0, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL lost_search: got %b want %b", w_obs, e); end
    repeat (15) tick();
    e = exp_v(2'd3, 3'd3, 1'b0, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL search_15: got %b want %b", w_obs, e); end
    tick();
    e = exp_v(2'd0, 3'd0, 1'b0, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL search_timeout: got %b want %b", w_obs, e); end
`else
    e = exp_v(2'd2, 3'd0, 1'b1, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL lost_stop_motor: got %b want %b", w_obs, e); end
    repeat (16) tick();
    e = exp_v(2'd2, 3'd0, 1'b1, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL lost_stay_auto: got %b want %b", w_obs, e); end
`endif
  endtask

  task automatic test_priority();
    vis_valid = 1'b1;
    vis_dir   = 3'd3;
    press(3'd5);
    tick();
    e = exp_v(2'd2, 3'd0, 1'b1, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL prio_auto: got %b want %b", w_obs, e); end
    repeat (4) tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL prio_deb4: got %b want %b", w_obs, e); end
    press(3'd2);
    tick();
    e = exp_v(2'd1, 3'd2, 1'b0, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL prio_ir_wins: got %b want %b", w_obs, e); end
    tick();
    e = exp_v(2'd1, 3'd2, 1'b0, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL prio_discard: got %b want %b", w_obs, e); end
  endtask

  task automatic test_search_reset();
    vis_valid = 1'b0;
    press(3'd5);
    tick();
    e = exp_v(2'd2, 3'd0, 1'b1, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL sr_auto: got %b want %b", w_obs, e); end
    repeat (8) tick();
`ifdef DRIVE_ARB_SEARCH_EN
    e = exp_v(2'd3, 3'd3, 1'b0, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL sr_search: got %b want %b", w_obs, e); end
    vis_valid = 1'b1;
    tick();
    e = exp_v(2'd2, 3'd0, 1'b1, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL search_found: got %b want %b", w_obs, e); end
    vis_valid = 1'b0;
    repeat (8) tick();
    e = exp_v(2'd3, 3'd3, 1'b0, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL sr_search2: got %b want %b", w_obs, e); end
`else
    e = exp_v(2'd2, 3'd0, 1'b1, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL sr_lost: got %b want %b", w_obs, e); end
`endif
    ir_cmd = 3'd1;
    resend = 1'b1;
    e = exp_v(2'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ir_toggle = ~ir_toggle;
      tick();
      n_checks++;
      if (w_obs !== e) begin n_fail++; $display("FAIL reset_in_search[%0d]: got %b want %b", i, w_obs, e); end
    end
    resend = 1'b0;
    tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL no_phantom_press: got %b want %b", w_obs, e); end
    tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL no_phantom_press2: got %b want %b", w_obs, e); end
  endtask

  task automatic test_ignore_repress();
    press(3'd1);
    tick();
    e = exp_v(2'd1, 3'd1, 1'b0, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL rp_first: got %b want %b", w_obs, e); end
    repeat (4) tick();
    press(3'd1);
    tick();
    e = exp_v(2'd1, 3'd1, 1'b0, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL repress_no_strobe: got %b want %b", w_obs, e); end
    repeat (9) tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL hold_reloaded: got %b want %b", w_obs, e); end
    tick();
    e = exp_v(2'd1, 3'd0, 1'b0, 1'b1);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL hold_expire: got %b want %b", w_obs, e); end
    press(3'd7);
    tick();
    e = exp_v(2'd1, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL ignore_7: got %b want %b", w_obs, e); end
    tick();
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL ignore_7_after: got %b want %b", w_obs, e); end
    press(3'd6);
    tick();
    e = exp_v(2'd0, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (w_obs !== e) begin n_fail++; $display("FAIL cmd6_stop: got %b want %b", w_obs, e); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_lost();
    test_priority();
    test_search_reset();
    test_ignore_repress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
